// File: rtl/model_dnc_pkg.sv
// Shared DNC read-path definitions: FSM state encoding and sizing constants.
// Used by model_read_interface_vector and model_nested_index_counter.
package model_dnc_pkg;

    typedef enum logic [1:0] {
        STARTER = 2'd0,
        KEY     = 2'd1,
        BETA    = 2'd2,
        MODE    = 2'd3
    } dnc_state_t;

    localparam logic [63:0] ZERO_CONTROL  = 64'd0;
    localparam logic [63:0] ONE_CONTROL   = 64'd1;
    localparam logic [63:0] TWO_CONTROL   = 64'd2;
    localparam logic [63:0] THREE_CONTROL = 64'd3;

    localparam logic [63:0] ZERO_DATA = 64'd0;
    localparam logic [63:0] ONE_DATA  = 64'd1;

    localparam int READ_MODES_SIZE = 3;

endpackage

// File: rtl/model_nested_index_counter.sv
// Two-level (i, j) index counter: j is the inner index, i the outer one.
// Both wrap to zero after the last (i, j) pair; i_clear forces both to zero.
module model_nested_index_counter
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [DATA_SIZE-1:0] i_limit_i,
    input  logic [DATA_SIZE-1:0] i_limit_j,
    output logic                 o_first_j,
    output logic                 o_last
);

    localparam int CMP_W = (DATA_SIZE > CONTROL_SIZE) ? DATA_SIZE : CONTROL_SIZE;

    logic [CONTROL_SIZE-1:0] r_i;
    logic [CONTROL_SIZE-1:0] r_j;
    logic [DATA_SIZE-1:0]    w_lim_i_m1;
    logic [DATA_SIZE-1:0]    w_lim_j_m1;
    logic                    w_last_i;
    logic                    w_last_j;

    assign w_lim_i_m1 = i_limit_i - DATA_SIZE'(ONE_DATA);
    assign w_lim_j_m1 = i_limit_j - DATA_SIZE'(ONE_DATA);

    // Counters are zero-extended against limits computed at data width
    assign w_last_i = (CMP_W'(r_i) == CMP_W'(w_lim_i_m1));
    assign w_last_j = (CMP_W'(r_j) == CMP_W'(w_lim_j_m1));

    assign o_first_j = (r_j == CONTROL_SIZE'(ZERO_CONTROL));
    assign o_last    = w_last_i && w_last_j;

    // Advance j each enabled step; carry into i when j wraps
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_clear) begin
            r_i <= '0;
            r_j <= '0;
        end else if (i_enable) begin
            if (w_last_j) begin
                r_j <= '0;
                if (w_last_i) begin
                    r_i <= '0;
                end else begin
                    r_i <= r_i + CONTROL_SIZE'(ONE_CONTROL);
                end
            end else begin
                r_j <= r_j + CONTROL_SIZE'(ONE_CONTROL);
            end
        end
    end

endmodule

// File: rtl/model_read_interface_vector.sv
// Demuxes the serialized read interface vector into keys, strengths, modes.
// MODEL_READ_INTERFACE_VECTOR_MODES_EN enables the read-mode (pi) field.
module model_read_interface_vector
    import model_dnc_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic                 XI_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] XI_IN,
    input  logic [DATA_SIZE-1:0] SIZE_R_IN,
    input  logic [DATA_SIZE-1:0] SIZE_W_IN,
    output logic                 K_OUT_I_ENABLE,
    output logic                 K_OUT_K_ENABLE,
    output logic [DATA_SIZE-1:0] K_OUT,
    output logic                 BETA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] BETA_OUT,
    output logic                 PI_OUT_I_ENABLE,
    output logic                 PI_OUT_P_ENABLE,
    output logic [DATA_SIZE-1:0] PI_OUT
);

    dnc_state_t           r_state;
    logic [DATA_SIZE-1:0] r_size_r;
    logic [DATA_SIZE-1:0] r_size_w;
    logic                 r_ready;
    logic                 r_k_i_en;
    logic                 r_k_k_en;
    logic [DATA_SIZE-1:0] r_k_out;
    logic                 r_beta_en;
    logic [DATA_SIZE-1:0] r_beta_out;
    logic [DATA_SIZE-1:0] w_limit_j;
    logic                 w_cnt_clear;
    logic                 w_cnt_en;
    logic                 w_first_j;
    logic                 w_last;

    assign w_cnt_clear = (r_state == STARTER);
    assign w_cnt_en    = XI_IN_ENABLE && (r_state != STARTER);

    // Inner loop length depends on the field being parsed
    always_comb begin
        w_limit_j = r_size_w;
        unique case (r_state)
            KEY:     w_limit_j = r_size_w;
            BETA:    w_limit_j = DATA_SIZE'(ONE_DATA);
            MODE:    w_limit_j = DATA_SIZE'(READ_MODES_SIZE);
            default: w_limit_j = r_size_w;
        endcase
    end

    model_nested_index_counter #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) u_cnt (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .i_limit_i (r_size_r),
        .i_limit_j (w_limit_j),
        .o_first_j (w_first_j),
        .o_last    (w_last)
    );

`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
    logic                 r_pi_i_en;
    logic                 r_pi_p_en;
    logic [DATA_SIZE-1:0] r_pi_out;
`endif

    // Parse FSM with registered field outputs and single-cycle enables
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= STARTER;
            r_size_r   <= '0;
            r_size_w   <= '0;
            r_ready    <= 1'b0;
            r_k_i_en   <= 1'b0;
            r_k_k_en   <= 1'b0;
            r_k_out    <= '0;
            r_beta_en  <= 1'b0;
            r_beta_out <= '0;
`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
            r_pi_i_en  <= 1'b0;
            r_pi_p_en  <= 1'b0;
            r_pi_out   <= '0;
`endif
        end else begin
            r_ready   <= 1'b0;
            r_k_i_en  <= 1'b0;
            r_k_k_en  <= 1'b0;
            r_beta_en <= 1'b0;
`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
            r_pi_i_en <= 1'b0;
            r_pi_p_en <= 1'b0;
`endif
            case (r_state)
                STARTER: begin
                    if (START) begin
                        r_size_r <= SIZE_R_IN;
                        r_size_w <= SIZE_W_IN;
                        if ((SIZE_R_IN == DATA_SIZE'(ZERO_DATA)) ||
                            (SIZE_W_IN == DATA_SIZE'(ZERO_DATA))) begin
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= KEY;
                        end
                    end
                end
                KEY: begin
                    if (XI_IN_ENABLE) begin
                        r_k_out  <= XI_IN;
                        r_k_k_en <= 1'b1;
                        r_k_i_en <= w_first_j;
                        if (w_last) begin
                            r_state <= BETA;
                        end
                    end
                end
                BETA: begin
                    if (XI_IN_ENABLE) begin
                        r_beta_out <= XI_IN;
                        r_beta_en  <= 1'b1;
                        if (w_last) begin
`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
                            r_state <= MODE;
`else
                            r_state <= STARTER;
                            r_ready <= 1'b1;
`endif
                        end
                    end
                end
`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
                MODE: begin
                    if (XI_IN_ENABLE) begin
                        r_pi_out  <= XI_IN;
                        r_pi_p_en <= 1'b1;
                        r_pi_i_en <= w_first_j;
                        if (w_last) begin
                            r_state <= STARTER;
                            r_ready <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= STARTER;
            endcase
        end
    end

    assign READY           = r_ready;
    assign K_OUT_I_ENABLE  = r_k_i_en;
    assign K_OUT_K_ENABLE  = r_k_k_en;
    assign K_OUT           = r_k_out;
    assign BETA_OUT_ENABLE = r_beta_en;
    assign BETA_OUT        = r_beta_out;

`ifdef MODEL_READ_INTERFACE_VECTOR_MODES_EN
    assign PI_OUT_I_ENABLE = r_pi_i_en;
    assign PI_OUT_P_ENABLE = r_pi_p_en;
    assign PI_OUT          = r_pi_out;
`else
    assign PI_OUT_I_ENABLE = 1'b0;
    assign PI_OUT_P_ENABLE = 1'b0;
    assign PI_OUT          = '0;
`endif

endmodule
